// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared rv32 constants and the compressed-instruction predicate
package rv32_pkg;

   localparam int HW_W = 16;
   localparam int BUF_HW = 3;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic is_compressed(input logic [HW_W-1:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/rv32_mod_fetch_aligner_if.sv
// rtl/rv32_mod_fetch_aligner_if.sv - instruction memory bus and decoder handshake
interface rv32_mod_fetch_aligner_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_is_compressed;

   modport master (
      output imem_req, imem_addr, instr_valid, instruction, instr_pc, instr_is_compressed,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instruction, instr_pc, instr_is_compressed,
      output imem_ack, imem_rdata, instr_ready
   );

endinterface

// File: rtl/rv32_mod_halfword_queue.sv
// rtl/rv32_mod_halfword_queue.sv - 3-entry halfword shift queue, pop applied before push
module rv32_mod_halfword_queue
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            pop1,
   input  logic            pop2,
   input  logic            push1,
   input  logic            push2,
   input  logic [HW_W-1:0] push_hw0,
   input  logic [HW_W-1:0] push_hw1,
   output logic [HW_W-1:0] hw0,
   output logic [HW_W-1:0] hw1,
   output logic [1:0]      count
);

   logic [HW_W-1:0] buf_q [BUF_HW];
   logic [HW_W-1:0] buf_d [BUF_HW];
   logic [HW_W-1:0] shifted [BUF_HW];
   logic [1:0]      count_q;
   logic [1:0]      count_d;
   logic [1:0]      base;

   always_comb begin
      shifted = buf_q;
      base    = count_q;
      if (pop2) begin
         shifted[0] = buf_q[2];
         shifted[1] = '0;
         shifted[2] = '0;
         base       = count_q - 2'd2;
      end else if (pop1) begin
         shifted[0] = buf_q[1];
         shifted[1] = buf_q[2];
         shifted[2] = '0;
         base       = count_q - 2'd1;
      end
      buf_d   = shifted;
      count_d = base;
      // new halfwords land right behind whatever survived the pop
      for (int i = 0; i < BUF_HW; i++) begin
         if ((push1 || push2) && 2'(i) == base) buf_d[i] = push_hw0;
         if (push2 && 2'(i) == base + 2'd1) buf_d[i] = push_hw1;
      end
      if (push2) count_d = base + 2'd2;
      else if (push1) count_d = base + 2'd1;
      if (flush) count_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_HW; i++) buf_q[i] <= '0;
         count_q <= '0;
      end else begin
         buf_q   <= buf_d;
         count_q <= count_d;
      end
   end

   assign hw0   = buf_q[0];
   assign hw1   = buf_q[1];
   assign count = count_q;

endmodule

// File: rtl/rv32_mod_fetch_aligner.sv
// rtl/rv32_mod_fetch_aligner.sv - word fetch, halfword realignment and PC tracking for the decoder
module rv32_mod_fetch_aligner
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            redirect_valid,
   input  logic [31:0]                     redirect_pc,
   rv32_mod_fetch_aligner_if.master        bus
);

   logic [31:0]     fetch_addr_q, fetch_addr_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [31:0]     pc_q, pc_d;
   logic            skip_lo_q, skip_lo_d;
   logic            drop_q, drop_d;
   logic            req_q, req_d;
   logic [HW_W-1:0] hw0, hw1;
   logic [1:0]      count;
   logic [1:0]      count_after;
   logic            ready_c, ready_32, accept, ack;
   logic            pop1, pop2, push1, push2;

   assign ready_c  = count >= 2'd1 && is_compressed(hw0);
   assign ready_32 = count >= 2'd2 && !is_compressed(hw0);
   assign accept   = bus.instr_valid && bus.instr_ready;
   assign pop1     = accept && ready_c;
   assign pop2     = accept && ready_32;
   assign ack      = req_q && bus.imem_ack;
   // data of a request issued before a redirect never enters the buffer
   assign push2    = ack && !drop_q && !redirect_valid && !skip_lo_q;
   assign push1    = ack && !drop_q && !redirect_valid && skip_lo_q;

   rv32_mod_halfword_queue u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .pop1     (pop1),
      .pop2     (pop2),
      .push1    (push1),
      .push2    (push2),
      .push_hw0 (skip_lo_q ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0]),
      .push_hw1 (bus.imem_rdata[31:16]),
      .hw0      (hw0),
      .hw1      (hw1),
      .count    (count)
   );

   always_comb begin
      count_after = count - {pop2, pop1} + {push2, push1};
      if (redirect_valid) count_after = '0;
   end

   always_comb begin
      fetch_addr_d = fetch_addr_q;
      skip_lo_d    = skip_lo_q;
      drop_d       = drop_q;
      pc_d         = pc_q;
      req_d        = req_q;
      req_addr_d   = req_addr_q;
      if (accept) pc_d = pc_q + (ready_c ? 32'd2 : 32'd4);
      if (push1 || push2) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
         skip_lo_d    = 1'b0;
      end
      if (ack && drop_q) drop_d = 1'b0;
      if (redirect_valid) begin
         pc_d         = redirect_pc & ~32'h1;
         fetch_addr_d = redirect_pc & ~32'h3;
         skip_lo_d    = redirect_pc[1];
         drop_d       = req_q && !bus.imem_ack;
      end
      // an outstanding request holds its address until acked
      if (!(req_q && !bus.imem_ack)) begin
         req_d      = count_after <= 2'd1;
         req_addr_d = fetch_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_addr_q <= RESET_PC & ~32'h3;
         req_addr_q   <= RESET_PC & ~32'h3;
         pc_q         <= RESET_PC;
         skip_lo_q    <= RESET_PC[1];
         drop_q       <= 1'b0;
         req_q        <= 1'b0;
      end else begin
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         pc_q         <= pc_d;
         skip_lo_q    <= skip_lo_d;
         drop_q       <= drop_d;
         req_q        <= req_d;
      end
   end

   assign bus.imem_req            = req_q;
   assign bus.imem_addr           = req_addr_q;
   assign bus.instr_pc            = pc_q;
   assign bus.instr_valid         = (ready_c || ready_32) && !redirect_valid;
   assign bus.instruction         = ready_c ? {16'h0000, hw0} : {hw1, hw0};
   assign bus.instr_is_compressed = ready_c;

endmodule
